apb_alu_slave: RTL and testbench



---
 rtl/apb_alu_if.sv | 39 +++
 rtl/apb_alu_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_apb_alu_slave.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/apb_alu_if.sv
// ---------------------------------------------------------------------------
// apb_alu_if
// APB bus bundle between the bridge (requester) and the ALU register bank
// (completer). Clock and reset stay outside the bundle as plain ports.
//
// Handshake: an access is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1). The requester holds PADDR/PWRITE/
// PWDATA/PSTRB stable until the rising edge at which PREADY=1. PREADY is a
// one-cycle pulse. PRDATA and PSLVERR mean something only while PREADY=1.
//
// Signals:
//   PSEL, PENABLE, PWRITE   requester -> completer  access control
//   PADDR[31:0]             requester -> completer  byte address
//   PSTRB[3:0]              requester -> completer  write byte enables
//   PWDATA[31:0]            requester -> completer  write data
//   PRDATA[31:0]            completer -> requester  read data
//   PREADY, PSLVERR         completer -> requester  completion / error
// ---------------------------------------------------------------------------
interface apb_alu_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_alu_slave.sv
// ---------------------------------------------------------------------------
// apb_alu_slave
// APB completer with a small ALU register bank. Single-cycle add/sub/logic/
// shift operations and a 32-cycle shift-add 32x32 unsigned multiply.
// Accesses that would disturb a running operation are held off with wait
// states until the operation finishes.
//
// Ports:
//   PCLK          clock, all logic on the rising edge
//   PRESETn       asynchronous active-low reset
//   apb           APB completer side (apb_alu_if.slave)
//   bus_state_o   bus FSM state (0 = B_IDLE, 1 = B_RESP)
//   alu_state_o   ALU FSM state (0 = A_IDLE, 1 = A_EXEC, 2 = A_MUL)
//
// Register map (offset from BASE_ADDR):
//   0x00 OPA  RW     0x04 OPB  RW     0x08 CTRL RW ([3:0] opcode, [8] start)
//   0x0C STATUS RO ([0] busy [1] done [2] zero [3] carry)
//   0x10 RES_LO RO   0x14 RES_HI RO   0x18/0x1C unmapped
// ---------------------------------------------------------------------------
module apb_alu_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  apb_alu_if.slave   apb,
  output logic       bus_state_o,
  output logic [1:0] alu_state_o
);

  typedef enum logic {B_IDLE = 1'b0, B_RESP = 1'b1} bus_state_e;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_EXEC = 2'd1, A_MUL = 2'd2} alu_state_e;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  bus_state_e  bus_state_q, bus_state_d;
  alu_state_e  alu_state_q, alu_state_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        busy_q, busy_d, done_q, done_d, zero_q, zero_d, carry_q, carry_d;
  logic [31:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  // Operand/opcode snapshot taken at start; only legal opcodes reach it.
  logic [31:0] sa_q, sa_d, sb_q, sb_d;
  logic [2:0]  sop_q, sop_d;
  // Multiply accumulator: upper half is the running partial sum, lower half
  // starts as the multiplier and is shifted out one bit per edge.
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        access, in_win, stall, err, alu_fin, start, fin_c;
  logic [2:0]  idx;
  logic [3:0]  new_op;
  logic [31:0] fin_lo, fin_hi, rdata;
  logic [32:0] sum33, mul_sum;

  // Byte offset bits inside a word carry no meaning.
  logic unused_paddr;
  assign unused_paddr = ^apb.PADDR[1:0];

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign bus_state_o = bus_state_q;
  assign alu_state_o = alu_state_q;

  always_comb begin
    bus_state_d = bus_state_q;
    alu_state_d = alu_state_q;
    prdata_d    = prdata_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opcode_d    = opcode_q;
    busy_d      = busy_q;
    done_d      = done_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    sop_d       = sop_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    alu_fin     = 1'b0;
    fin_lo      = '0;
    fin_hi      = '0;
    fin_c       = 1'b0;
    sum33       = '0;
    mul_sum     = '0;

    // ---------------- ALU FSM ----------------
    case (alu_state_q)
      A_EXEC: begin
        alu_fin     = 1'b1;
        alu_state_d = A_IDLE;
        case (sop_q)
          OP_ADD: begin
            sum33  = {1'b0, sa_q} + {1'b0, sb_q};
            fin_lo = sum33[31:0];
            fin_c  = sum33[32];
          end
          OP_SUB: begin
            fin_lo = sa_q - sb_q;
            fin_c  = (sa_q < sb_q);
          end
          OP_AND:  fin_lo = sa_q & sb_q;
          OP_OR:   fin_lo = sa_q | sb_q;
          OP_XOR:  fin_lo = sa_q ^ sb_q;
          OP_SHL:  fin_lo = sa_q << sb_q[4:0];
          OP_SHR:  fin_lo = sa_q >> sb_q[4:0];
          default: fin_lo = '0;
        endcase
      end
      A_MUL: begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, sa_q} : 33'd0);
        acc_d   = {mul_sum, acc_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          alu_fin          = 1'b1;
          alu_state_d      = A_IDLE;
          {fin_hi, fin_lo} = acc_d;
        end
      end
      default: ;
    endcase

    if (alu_fin) begin
      res_lo_d = fin_lo;
      res_hi_d = fin_hi;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      zero_d   = ({fin_hi, fin_lo} == 64'd0);
      carry_d  = fin_c;
    end

    // ---------------- Bus decode ----------------
    access = apb.PSEL & apb.PENABLE & ~pready_q;
    in_win = (apb.PADDR[31:5] == BASE_ADDR[31:5]);
    idx    = apb.PADDR[4:2];
    new_op = apb.PSTRB[0] ? apb.PWDATA[3:0] : opcode_q;
    start  = apb.PSTRB[1] & apb.PWDATA[8];
    // The edge on which the ALU finishes counts as not busy, so a held-off
    // access is taken on that same edge and sees the fresh result.
    stall  = busy_q & ~alu_fin & in_win &
             (apb.PWRITE ? (idx <= 3'd2) : ((idx == 3'd4) || (idx == 3'd5)));
    err    = ~in_win | (idx[2] & idx[1]) |
             (apb.PWRITE & (idx >= 3'd3) & (idx <= 3'd5)) |
             (apb.PWRITE & (idx == 3'd2) & start & new_op[3]);

    case (idx)
      3'd0:    rdata = opa_q;
      3'd1:    rdata = opb_q;
      3'd2:    rdata = {28'd0, opcode_q};
      3'd3:    rdata = {28'd0, carry_q, zero_q, done_q, busy_q};
      3'd4:    rdata = res_lo_d;
      3'd5:    rdata = res_hi_d;
      default: rdata = '0;
    endcase

    // ---------------- Bus FSM ----------------
    case (bus_state_q)
      B_IDLE: begin
        if (access && !stall) begin
          bus_state_d = B_RESP;
          pready_d    = 1'b1;
          pslverr_d   = err;
          if (!err) begin
            if (apb.PWRITE) begin
              case (idx)
                3'd0: for (int i = 0; i < 4; i++)
                        if (apb.PSTRB[i]) opa_d[8*i +: 8] = apb.PWDATA[8*i +: 8];
                3'd1: for (int i = 0; i < 4; i++)
                        if (apb.PSTRB[i]) opb_d[8*i +: 8] = apb.PWDATA[8*i +: 8];
                3'd2: begin
                  opcode_d = new_op;
                  if (start) begin
                    sa_d    = opa_q;
                    sb_d    = opb_q;
                    sop_d   = new_op[2:0];
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    zero_d  = 1'b0;
                    carry_d = 1'b0;
                    if (new_op[2:0] == OP_MUL) begin
                      alu_state_d = A_MUL;
                      acc_d       = {32'd0, opb_q};
                      cnt_d       = 5'd0;
                    end else begin
                      alu_state_d = A_EXEC;
                    end
                  end
                end
                default: ;
              endcase
            end else begin
              prdata_d = rdata;
              // Reading the low result consumes it.
              if (idx == 3'd4) done_d = 1'b0;
            end
          end
        end
      end
      B_RESP: begin
        bus_state_d = B_IDLE;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
      end
      default: bus_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus_state_q <= B_IDLE;
      alu_state_q <= A_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      opcode_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      sop_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      alu_state_q <= alu_state_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opcode_q    <= opcode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sop_q       <= sop_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_alu_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_alu_slave
// Directed bench for apb_alu_slave: reset values, ALU operations, multiply
// with wait states, byte enables, error responses and reset mid-multiply.
// ---------------------------------------------------------------------------
module tb_apb_alu_slave;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       bus_state_o;
  logic [1:0] alu_state_o;

  apb_alu_if apb ();

  apb_alu_slave #(.BASE_ADDR(32'h0000_0000)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .apb         (apb),
    .bus_state_o (bus_state_o),
    .alu_state_o (alu_state_o)
  );

  // ---------------- clock ----------------
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(posedge PCLK); #1;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PSTRB   = wr ? strb : 4'b0000;
    apb.PWDATA  = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    waits = 0;
    do begin
      @(posedge PCLK); #1;
      waits++;
    end while (!apb.PREADY && waits < 200);
    if (!apb.PREADY) begin
      n_cmp++;
      n_err++;
      $error("FAIL timeout addr %h: observed no PREADY, expected PREADY within 200 cycles", addr);
    end
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    chk("pready_pulse", {31'd0, apb.PREADY}, 32'd0);
  endtask

  task automatic do_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, addr, data, strb, rd, e, w);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic do_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b0, addr, 32'd0, 4'd0, rd, e, w);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    if (!exp_err) chk(tag, rd, exp_data);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [31:0] rd;
    logic        e;
    int          w;

    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PSTRB   = '0;
    apb.PWDATA  = '0;
    PRESETn     = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_prdata", apb.PRDATA, 32'd0);
    chk("rst_pready", {31'd0, apb.PREADY}, 32'd0);
    chk("rst_pslverr", {31'd0, apb.PSLVERR}, 32'd0);
    chk("rst_bus_state", {31'd0, bus_state_o}, 32'd0);
    chk("rst_alu_state", {30'd0, alu_state_o}, 32'd0);
    PRESETn = 1'b1;
    do_rd("rst_status", 32'h0C, 32'd0, 1'b0);
    do_rd("rst_opa", 32'h00, 32'd0, 1'b0);

    // ADD with carry-out and zero result
    do_wr("add_opa", 32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
    do_wr("add_opb", 32'h04, 32'h0000_0001, 4'hF, 1'b0);
    do_wr("add_ctrl", 32'h08, 32'h0000_0100, 4'hF, 1'b0);
    do_rd("add_status", 32'h0C, 32'h0000_000E, 1'b0);
    apb_xfer(1'b0, 32'h10, 32'd0, 4'd0, rd, e, w);
    chk("add_res_lo", rd, 32'd0);
    chk("min_latency", w, 32'd1);
    do_rd("add_res_hi", 32'h14, 32'd0, 1'b0);
    do_rd("add_status_after_rd", 32'h0C, 32'h0000_000C, 1'b0);

    // SUB with borrow
    do_wr("sub_opa", 32'h00, 32'd3, 4'hF, 1'b0);
    do_wr("sub_opb", 32'h04, 32'd5, 4'hF, 1'b0);
    do_wr("sub_ctrl", 32'h08, 32'h0000_0101, 4'hF, 1'b0);
    do_rd("sub_status", 32'h0C, 32'h0000_000A, 1'b0);
    do_rd("sub_res_lo", 32'h10, 32'hFFFF_FFFE, 1'b0);

    // SHL uses only OPB[4:0]
    do_wr("shl_opa", 32'h00, 32'd1, 4'hF, 1'b0);
    do_wr("shl_opb", 32'h04, 32'h0000_0023, 4'hF, 1'b0);
    do_wr("shl_ctrl", 32'h08, 32'h0000_0105, 4'hF, 1'b0);
    do_rd("shl_status", 32'h0C, 32'h0000_0002, 1'b0);
    do_rd("shl_res_lo", 32'h10, 32'd8, 1'b0);

    // MUL with a RES_LO read held off until the multiply finishes
    do_wr("mul_opa", 32'h00, 32'h1234_5678, 4'hF, 1'b0);
    do_wr("mul_opb", 32'h04, 32'h9ABC_DEF0, 4'hF, 1'b0);
    do_wr("mul_ctrl", 32'h08, 32'h0000_0107, 4'hF, 1'b0);
    apb_xfer(1'b0, 32'h10, 32'd0, 4'd0, rd, e, w);
    chk("mul_res_lo", rd, 32'h242D_2080);
    chk("mul_stall_waits", w, 32'd29);
    chk("mul_res_lo_err", {31'd0, e}, 32'd0);
    do_rd("mul_res_hi", 32'h14, 32'h0B00_EA4E, 1'b0);
    apb_xfer(1'b0, 32'h0C, 32'd0, 4'd0, rd, e, w);
    chk("mul_busy_clear", {31'd0, rd[0]}, 32'd0);

    // Byte enables
    do_wr("strb_clr", 32'h00, 32'd0, 4'hF, 1'b0);
    do_wr("strb_0101", 32'h00, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_rd("strb_opa", 32'h00, 32'h00BB_00DD, 1'b0);
    do_wr("strb_none", 32'h00, 32'h1111_1111, 4'b0000, 1'b0);
    do_rd("strb_none_opa", 32'h00, 32'h00BB_00DD, 1'b0);

    // Error responses, no side effects
    do_rd("err_unmapped", 32'h18, 32'd0, 1'b1);
    do_wr("err_wr_status", 32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1);
    do_wr("err_window_wr", 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
    do_rd("err_window_rd", 32'h24, 32'd0, 1'b1);
    do_rd("err_opa_kept", 32'h00, 32'h00BB_00DD, 1'b0);
    do_wr("err_illegal_op", 32'h08, 32'h0000_010A, 4'hF, 1'b1);
    do_rd("err_ctrl_kept", 32'h08, 32'h0000_0007, 1'b0);
    apb_xfer(1'b0, 32'h0C, 32'd0, 4'd0, rd, e, w);
    chk("err_no_busy", {31'd0, rd[0]}, 32'd0);

    // Reset in the middle of a multiply
    do_wr("rm_ctrl", 32'h08, 32'h0000_0107, 4'hF, 1'b0);
    do_rd("rm_status_busy", 32'h0C, 32'h0000_0001, 1'b0);
    repeat (4) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("rm_prdata", apb.PRDATA, 32'd0);
    chk("rm_pready", {31'd0, apb.PREADY}, 32'd0);
    chk("rm_pslverr", {31'd0, apb.PSLVERR}, 32'd0);
    chk("rm_alu_state", {30'd0, alu_state_o}, 32'd0);
    chk("rm_bus_state", {31'd0, bus_state_o}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    do_rd("rm_status", 32'h0C, 32'd0, 1'b0);
    do_rd("rm_res_lo", 32'h10, 32'd0, 1'b0);
    do_rd("rm_res_hi", 32'h14, 32'd0, 1'b0);
    do_rd("rm_opa", 32'h00, 32'd0, 1'b0);
    do_rd("rm_opb", 32'h04, 32'd0, 1'b0);
    do_rd("rm_ctrl_rd", 32'h08, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
